// File: rtl/sqrt_share_arbiter.sv
// Round-robin share of one sqrt unit across N_REQ lanes; accept->LOAD->WAIT, resp one cycle after sq_rdy.
// One op in flight; req_ready only in IDLE, result held until resp_ready, watchdog aborts a stuck WAIT.
module sqrt_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_err,
  input  logic                   resp_ready,
  output logic                   sq_rst,
  output logic [WIDTH-1:0]       sq_a,
  input  logic                   sq_rdy,
  input  logic [WIDTH-1:0]       sq_sqrt,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  int                scan_idx;

  // First valid lane at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_vld && req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (sq_rdy || wait_cnt == CNT_LAST) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      sq_rst      <= 1'b0;
      sq_a        <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            sq_a    <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
            resp_id <= gnt_idx;
            rr_ptr  <= ID_W'((int'(gnt_idx) + 1) % N_REQ);
            sq_rst  <= 1'b1;
          end
        end
        // sq_rdy may still be high from the previous op, so it is not looked at here.
        S_LOAD: begin
          sq_rst   <= 1'b0;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (sq_rdy) begin
            resp_data  <= sq_sqrt;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            resp_data   <= QNAN;
            resp_err    <= 1'b1;
            timeout_err <= 1'b1;
            resp_valid  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Bench for sqrt_share_arbiter: behavioural sqrt stub, directed requests, queue scoreboard.
module tb_sqrt_share_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [127:0]  req_data = '0;
  logic [3:0]    req_ready;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          resp_ready = 1'b1;
  logic          sq_rst;
  logic [31:0]   sq_a;
  logic          sq_rdy;
  logic [31:0]   sq_sqrt;
  logic          busy;
  logic          timeout_err;

  sqrt_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready),
    .sq_rst(sq_rst), .sq_a(sq_a), .sq_rdy(sq_rdy), .sq_sqrt(sq_sqrt),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Sqrt unit stub: zero finishes on the first WAIT cycle, others after stub_lat cycles.
  int          stub_lat  = 5;
  logic        stub_dead = 1'b0;
  int          stub_cnt  = 0;
  logic        stub_rdy  = 1'b0;
  logic [31:0] stub_res  = '0;

  function automatic logic [31:0] sqrt_tab(input logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      32'h0000_0000: return 32'h0000_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (sq_rst) begin
      stub_res <= sqrt_tab(sq_a);
      stub_rdy <= (sq_a == 32'h0);
      stub_cnt <= (sq_a == 32'h0) ? 0 : stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_rdy <= 1'b1;
    end
  end
  assign sq_rdy  = stub_rdy && !stub_dead;
  assign sq_sqrt = stub_res;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: compares every accepted response against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got id=%0d data=%h, none expected", resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_err", 64'(resp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise the lanes in mask with operand op, wait for the grant and check it.
  task automatic do_req(input logic [3:0] mask, input int exp_g, input logic [31:0] op,
                        input logic [31:0] exp_res, input logic exp_err, input bit push);
    bit got;
    exp_t e;
    got = 0;
    @(negedge clk);
    req_data  = {4{op}};
    req_valid = mask;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (|req_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_wait: got no grant, expected lane %0d", exp_g);
    end else begin
      chk("grant", 64'(req_ready), 64'(4'b1 << exp_g));
      if (push) begin
        e.id = 2'(exp_g); e.data = exp_res; e.err = exp_err;
        exp_q.push_back(e);
      end
    end
  endtask

  // Counts cycles from the accept until resp_valid, and sq_rst-high cycles on the way.
  task automatic wait_done(input bit until_resp, output int lat, output int nrst);
    bit done;
    lat  = -1;
    nrst = 0;
    done = 0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
      #1;
      if (sq_rst) nrst++;
      if (resp_valid && lat < 0) lat = n;
      if (until_resp ? resp_valid : !busy) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_wait: busy=%0d resp_valid=%0d after 200 cycles", busy, resp_valid);
    end
  endtask

  initial begin
    int lat, nrst;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_sq_rst", 64'(sq_rst), 64'd0);
    chk("rst_sq_a", 64'(sq_a), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Lane 1: sqrt(4.0) = 2.0, single sq_rst pulse
    do_req(4'b0010, 1, 32'h4080_0000, 32'h4000_0000, 1'b0, 1);
    wait_done(0, lat, nrst);
    chk("sq_rst_pulse_cycles", 64'(nrst), 64'd1);

    // Lanes 0,2,3 with 16.0 from rr_ptr=0: grants 0,2,3
    do_reset();
    do_req(4'b1101, 0, 32'h4180_0000, 32'h4080_0000, 1'b0, 1);
    wait_done(0, lat, nrst);
    do_req(4'b1101, 2, 32'h4180_0000, 32'h4080_0000, 1'b0, 1);
    wait_done(0, lat, nrst);
    do_req(4'b1101, 3, 32'h4180_0000, 32'h4080_0000, 1'b0, 1);
    wait_done(0, lat, nrst);

    // All lanes valid: rr_ptr wrapped to 0 so lane 0 wins; zero operand, latency 3
    do_req(4'b1111, 0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    wait_done(0, lat, nrst);
    chk("zero_latency", 64'(lat), 64'd3);

    // 1.0 on lane 2 with resp_ready held low for 10 cycles
    resp_ready = 1'b0;
    do_req(4'b0100, 2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1);
    wait_done(1, lat, nrst);
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_resp_valid", 64'(resp_valid), 64'd1);
      chk("stall_resp_data", 64'(resp_data), 64'h3F80_0000);
      chk("stall_resp_id", 64'(resp_id), 64'd2);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = '0;
    @(negedge clk);
    #1;
    chk("release_idle_busy", 64'(busy), 64'd0);

    // Dead sqrt unit: watchdog abort after TIMEOUT WAIT cycles
    stub_dead = 1'b1;
    do_req(4'b1000, 3, 32'h4080_0000, 32'h7FC0_0000, 1'b1, 1);
    wait_done(0, lat, nrst);
    chk("timeout_latency", 64'(lat), 64'd42);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    stub_dead = 1'b0;
    do_req(4'b0001, 0, 32'h4080_0000, 32'h4000_0000, 1'b0, 1);
    wait_done(0, lat, nrst);
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Reset in WAIT: op dropped, rr_ptr back to 0
    stub_lat = 20;
    do_req(4'b0010, 1, 32'h4080_0000, 32'h4000_0000, 1'b0, 0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
    end
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    do_reset();
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
    repeat (30) @(negedge clk);
    stub_lat = 5;
    do_req(4'b1111, 0, 32'h4080_0000, 32'h4000_0000, 1'b0, 1);
    wait_done(0, lat, nrst);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
